sipo_frame_ctrl: RTL and testbench

- Frame controller that sequences a DATA_WIDTH-bit serial-in/parallel-out shift register.
- Aligns serial frames on a start-of-frame marker and counts bits in.
- Presents each completed word on a valid/ready output handshake, holding it stable under backpressure.
- Flags resync and overrun errors, and counts delivered frames. Sits between a serial link front-end and a parallel word consumer.

---
 rtl/sipo_frame_pkg.sv | 17 +
 rtl/sipo_shift_reg.sv | 33 +++
 rtl/sipo_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_pkg.sv
// sipo_frame_pkg
//   Shared types and helpers for the serial-in/parallel-out frame controller.
//   - state_t   : controller FSM states
//   - bit_cnt_w : width needed for a counter that reaches DATA_WIDTH
package sipo_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int bit_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg
//   DATA_WIDTH-bit shift register, MSB-first; the newest bit enters at q[0].
//   Ports:
//     clk      in  clock, rising edge
//     resetn   in  asynchronous active-low reset, clears q
//     shift_en in  shift din in
//     restart  in  clear and load din as the first bit (wins over shift_en)
//     din      in  serial bit
//     q        out register contents
module sipo_shift_reg
    import sipo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  shift_en,
    input  logic                  restart,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (restart) begin
            q <= {{(DATA_WIDTH-1){1'b0}}, din};
        end else if (shift_en) begin
            q <= {q[DATA_WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
//   Aligns serial frames on sof, assembles DATA_WIDTH-bit words and presents
//   them on a valid/ready handshake, holding the word under backpressure.
//   Ports:
//     clk, resetn       clock / asynchronous active-low reset
//     din, din_valid    serial bit and its qualifier (MSB first)
//     sof               din is the first bit of a frame
//     dout_ready        consumer accepts dout
//     clr_err           clears sticky overrun
//     dout, dout_valid  assembled word and its valid
//     busy              frame partially received
//     frame_err         one-cycle pulse when sof restarts a partial frame
//     overrun           sticky: bits dropped while a word was held
//     frame_cnt         delivered-frame counter, wraps
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  sof,
    input  logic                  dout_ready,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int            BW   = bit_cnt_w(DATA_WIDTH);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    state_t          state, state_d;
    logic [BW-1:0]   bit_cnt, cnt_d;
    logic            shift_en, restart, ferr_d, ovr_set, xfer;

    sipo_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_sreg (
        .clk      (clk),
        .resetn   (resetn),
        .shift_en (shift_en),
        .restart  (restart),
        .din      (din),
        .q        (dout)
    );

    assign dout_valid = (state == HOLD);
    assign busy       = (state == SHIFT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= cnt_d;
            frame_err <= ferr_d;
            // A drop in the same cycle as clr_err must not be lost.
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (xfer) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = bit_cnt;
        shift_en = 1'b0;
        restart  = 1'b0;
        ferr_d   = 1'b0;
        ovr_set  = 1'b0;
        xfer     = 1'b0;
        case (state)
            IDLE: begin
                // Bits without sof are line noise here and silently discarded.
                if (din_valid && sof) begin
                    restart = 1'b1;
                    cnt_d   = BW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (din_valid) begin
                    if (sof) begin
                        restart = 1'b1;
                        cnt_d   = BW'(1);
                        ferr_d  = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        cnt_d    = bit_cnt + BW'(1);
                        if (bit_cnt == LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (dout_ready) begin
                    xfer = 1'b1;
                    if (din_valid && sof) begin
                        // Back-to-back frame: next word starts on the transfer edge.
                        restart = 1'b1;
                        cnt_d   = BW'(1);
                        state_d = SHIFT;
                    end else begin
                        ovr_set = din_valid;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    ovr_set = din_valid;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        sof = 1'b0;
    logic        dout_ready = 1'b1;
    logic        clr_err = 1'b0;

    logic [15:0] dout;
    logic        dout_valid, busy, frame_err, overrun;
    logic [15:0] frame_cnt;

    logic [15:0] dout2;
    logic        dout_valid2, busy2, frame_err2, overrun2;
    logic [1:0]  frame_cnt2;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int vld_seen = 0;
    int busy_seen = 0;

    sipo_frame_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .sof(sof),
        .dout_ready(dout_ready), .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .frame_err(frame_err), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    sipo_frame_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .sof(sof),
        .dout_ready(dout_ready), .clr_err(clr_err), .dout(dout2), .dout_valid(dout_valid2),
        .busy(busy2), .frame_err(frame_err2), .overrun(overrun2), .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_err) ferr_seen++;
        if (dout_valid) vld_seen++;
        if (busy) busy_seen++;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        resetn    = 1'b1;
        ferr_seen = 0;
        vld_seen  = 0;
        busy_seen = 0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gap);
        for (int i = 15; i >= 0; i--) begin
            if (gap && i != 15) begin
                din_valid = 1'b0;
                sof       = 1'b0;
                tick();
            end
            din       = w[i];
            din_valid = 1'b1;
            sof       = (i == 15);
            tick();
        end
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    logic [15:0] words [5];

    initial begin
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        words[3] = 16'h4444; words[4] = 16'h5555;

        // Reset state, asserted before any clock edge
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check_val("rst_dout", dout, 16'h0);
        check_val("rst_valid", dout_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovr", overrun, 0);
        check_val("rst_cnt", frame_cnt, 0);

        // 1: basic frame
        do_reset();
        dout_ready = 1'b1;
        send_word(16'hA5C3, 1'b0);
        check_val("t1_valid", dout_valid, 1);
        check_val("t1_dout", dout, 16'hA5C3);
        check_val("t1_busy_cycles", busy_seen, 15);
        tick();
        check_val("t1_valid_drop", dout_valid, 0);
        check_val("t1_cnt", frame_cnt, 1);
        tick();
        check_val("t1_valid_cycles", vld_seen, 1);
        check_val("t1_busy_idle", busy, 0);

        // 2: gaps and backpressure
        do_reset();
        dout_ready = 1'b0;
        send_word(16'h5A0F, 1'b1);
        check_val("t2_valid", dout_valid, 1);
        check_val("t2_dout", dout, 16'h5A0F);
        check_val("t2_ovr_pre", overrun, 0);
        for (int c = 0; c < 10; c++) begin
            din       = 1'b1;
            din_valid = (c == 2 || c == 5 || c == 8);
            tick();
        end
        din_valid = 1'b0;
        check_val("t2_dout_held", dout, 16'h5A0F);
        check_val("t2_valid_held", dout_valid, 1);
        check_val("t2_ovr", overrun, 1);
        check_val("t2_cnt_held", frame_cnt, 0);
        dout_ready = 1'b1;
        tick();
        check_val("t2_cnt", frame_cnt, 1);
        check_val("t2_valid_drop", dout_valid, 0);
        check_val("t2_ovr_sticky", overrun, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_val("t2_ovr_clr", overrun, 0);

        // 3: resync
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din       = i[0];
            din_valid = 1'b1;
            sof       = (i == 0);
            tick();
        end
        check_val("t3_ferr_none", ferr_seen, 0);
        send_word(16'h1234, 1'b0);
        check_val("t3_ferr_once", ferr_seen, 1);
        check_val("t3_dout", dout, 16'h1234);
        check_val("t3_valid", dout_valid, 1);
        dout_ready = 1'b1;
        tick();
        check_val("t3_cnt", frame_cnt, 1);
        check_val("t3_ovr", overrun, 0);

        // 4: back-to-back
        do_reset();
        dout_ready = 1'b1;
        send_word(16'hC0DE, 1'b0);
        check_val("t4_dout1", dout, 16'hC0DE);
        din = 1'b1; din_valid = 1'b1; sof = 1'b1;
        tick();
        check_val("t4_cnt1", frame_cnt, 1);
        check_val("t4_busy", busy, 1);
        check_val("t4_valid_gap", dout_valid, 0);
        sof = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        din_valid = 1'b0;
        check_val("t4_dout2", dout, 16'hFFFF);
        check_val("t4_valid2", dout_valid, 1);
        check_val("t4_ovr", overrun, 0);
        tick();
        check_val("t4_cnt2", frame_cnt, 2);

        // 5: reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) begin
            din       = (i != 1 && i != 4);
            din_valid = 1'b1;
            sof       = (i == 0);
            tick();
        end
        din_valid = 1'b0;
        sof = 1'b0;
        check_val("t5_partial", dout, 16'h0016);
        check_val("t5_busy_pre", busy, 1);
        resetn = 1'b0;
        #2;
        check_val("t5_dout_rst", dout, 16'h0);
        check_val("t5_busy_rst", busy, 0);
        check_val("t5_valid_rst", dout_valid, 0);
        tick();
        resetn = 1'b1;
        send_word(16'h8001, 1'b0);
        check_val("t5_dout", dout, 16'h8001);
        tick();
        check_val("t5_cnt", frame_cnt, 1);

        // 6: idle noise and counter wrap
        do_reset();
        dout_ready = 1'b1;
        din = 1'b1; din_valid = 1'b1; sof = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        din_valid = 1'b0;
        check_val("t6_noise_busy", busy2, 0);
        check_val("t6_noise_dout", dout2, 16'h0);
        check_val("t6_noise_ovr", overrun2, 0);
        check_val("t6_noise_ferr", ferr_seen, 0);
        for (int f = 0; f < 5; f++) begin
            send_word(words[f], 1'b0);
            tick();
        end
        check_val("t6_dout_last", dout2, 16'h5555);
        check_val("t6_cnt_wrap", frame_cnt2, 1);
        check_val("t6_cnt_full", frame_cnt, 5);
        check_val("t6_ovr", overrun2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
